// File: rtl/div_restoring_pkg.sv
// Shared datapath package: divider FSM encoding, default operand width, result bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_restoring_pkg;

  // Default operand width for dividend, divisor, quotient and remainder.
  localparam int WIDTH_DEF = 4;

  // Divider control states. RUN lasts WIDTH cycles and DONE exactly one.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the iteration counter, which must hold the value WIDTH.
  function automatic int count_width(input int width);
    return (width < 2) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_restoring_shl.sv
// Shift-left register with parallel load, serial-in and shift enable.
// Latency: one clock from load/shift_en to q; load wins over shift.
// Backpressure: none; the register updates whenever load or shift_en is set.
module shl_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         sin,
  output logic [W-1:0] q
);

  // Load has priority so a caller can override the shift with a computed value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/div_restoring.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency: start sampled at edge 0, busy for WIDTH cycles, done pulse in cycle WIDTH+1.
// Backpressure: start is only sampled in IDLE; requests in RUN or DONE are dropped.
module div_restoring
  import div_restoring_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = count_width(WIDTH);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH:0]   a_q;        // partial remainder, one guard bit
  logic [WIDTH-1:0] q_q;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] m_q;        // captured divisor
  logic [CW-1:0]    count;
  logic             dz_cap;     // divisor was zero at capture time

  logic             start_acc;
  logic             run;
  logic             last;

  logic [WIDTH:0]   a_shl;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             a_load;
  logic [WIDTH:0]   a_load_val;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // Trial subtraction of the divisor from the left-shifted partial remainder.
  // The top bit of the WIDTH+1-bit difference is the borrow.
  assign a_shl  = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial  = a_shl - {1'b0, m_q};
  assign borrow = trial[WIDTH];

  // Values the A/Q pair will hold after the current iteration; used to load
  // the result registers on the final iteration so they are valid in DONE.
  assign q_fin = {q_q[WIDTH-2:0], ~borrow};
  assign r_fin = borrow ? a_shl[WIDTH-1:0] : trial[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE on the last iteration,
  // DONE -> IDLE unconditionally.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (count == CW'(1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath control decode from the current state.
  always_comb begin
    start_acc = 1'b0;
    run       = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: start_acc = start;
      ST_RUN: begin
        run  = 1'b1;
        busy = 1'b1;
        last = (count == CW'(1));
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // A reuses the shift path for the restore case (shifted value kept) and the
  // load path both for clearing on start and for taking the difference.
  always_comb begin
    a_load     = start_acc | (run & ~borrow);
    a_load_val = start_acc ? '0 : trial;
  end

  shl_reg #(.W(WIDTH + 1)) u_a_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (a_load),
    .load_val (a_load_val),
    .shift_en (run),
    .sin      (q_q[WIDTH-1]),
    .q        (a_q)
  );

  // Q takes the dividend on start, then shifts in one quotient bit per cycle.
  shl_reg #(.W(WIDTH)) u_q_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc),
    .load_val (dividend),
    .shift_en (run),
    .sin      (~borrow),
    .q        (q_q)
  );

  // Divisor, divide-by-zero flag and iteration counter; operands are only
  // captured on an accepted start so later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q    <= '0;
      count  <= '0;
      dz_cap <= 1'b0;
    end else if (start_acc) begin
      m_q    <= divisor;
      count  <= CW'(WIDTH);
      dz_cap <= (divisor == '0);
    end else if (run) begin
      count  <= count - CW'(1);
    end
  end

  // Result registers update only on the final iteration and otherwise hold,
  // so a new start does not disturb the previous answer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (last) begin
      quotient  <= q_fin;
      remainder <= r_fin;
      div_zero  <= dz_cap;
    end
  end

endmodule

// File: tb/tb_div_restoring.sv
// Self-checking bench for div_restoring: directed cases plus random operands.
// Expected results come from integer division of the captured operands.
// Every comparison is an immediate assertion counted in n_checks / n_fail.
module tb_div_restoring;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  div_restoring #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the stimulus is fixed-length, this only fires if time runs away.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention
  // of quotient all ones and remainder equal to the dividend.
  task automatic ref_div(input int a, input int b, output int q, output int r, output int dz);
    if (b == 0) begin
      q = MASK; r = a; dz = 1;
    end else begin
      q = a / b; r = a % b; dz = 0;
    end
  endtask

  // Called at a negedge; issues start there (sampled at the next rising edge,
  // "edge 0"), then checks busy for cycles 1..W, done and results in cycle W+1,
  // and that done has dropped with results held in cycle W+2. Returns at the
  // cycle W+2 negedge. If inj_cycle > 0 a second start with other operands is
  // pulsed in that cycle and must be ignored.
  task automatic do_div(input string tag, input int a, input int b, input int inj_cycle,
                        input int ia, input int ib);
    int eq, er, edz;
    ref_div(a, b, eq, er, edz);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      start    = 1'b0;
      // Captured operands only: scramble the inputs during the run.
      dividend = W'($urandom);
      divisor  = W'($urandom);
      if (c == inj_cycle) begin
        dividend = W'(ia);
        divisor  = W'(ib);
        start    = 1'b1;
      end
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " no early done"}, 32'(done), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy low at done"}, 32'(busy), 32'd0);
    chk({tag, " quotient"}, 32'(quotient), 32'(eq));
    chk({tag, " remainder"}, 32'(remainder), 32'(er));
    chk({tag, " div_zero"}, 32'(div_zero), 32'(edz));
    if (edz == 0) begin
      chk({tag, " q*d+r"}, 32'(int'(quotient) * b + int'(remainder)), 32'(a));
      chk({tag, " r<d"}, 32'(int'(remainder) < b), 32'd1);
    end
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
    chk({tag, " quotient held"}, 32'(quotient), 32'(eq));
    chk({tag, " remainder held"}, 32'(remainder), 32'(er));
  endtask

  initial begin
    int pa, pb;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset then idle: all outputs zero, both during and after reset.
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset div_zero", 32'(div_zero), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle done", 32'(done), 32'd0);

    // Directed cases.
    do_div("13/3", 13, 3, 0, 0, 0);
    do_div("15/1", 15, 1, 0, 0, 0);
    do_div("3/9", 3, 9, 0, 0, 0);
    do_div("15/15", 15, 15, 0, 0, 0);
    do_div("0/5", 0, 5, 0, 0, 0);
    do_div("7/0", 7, 0, 0, 0, 0);
    do_div("6/2", 6, 2, 0, 0, 0);

    // Start with 9/2 pulsed in cycle 2 of 13/3 is ignored; the return lands
    // in cycle 6, so the following 9/2 run sees done in cycle 11.
    do_div("13/3 inj", 13, 3, 2, 9, 2);
    do_div("9/2 after", 9, 2, 0, 0, 0);

    // Asynchronous reset mid-run, between clock edges in cycle 3.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    chk("pre-reset quotient held", 32'(quotient), 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset quotient", 32'(quotient), 32'd0);
    chk("async reset remainder", 32'(remainder), 32'd0);
    chk("async reset div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < W + 2; c++) begin
      @(negedge clk);
      chk("no done after reset", 32'(done), 32'd0);
      chk("no busy after reset", 32'(busy), 32'd0);
    end
    do_div("10/4", 10, 4, 0, 0, 0);

    // Random operands, back to back, zero divisor allowed.
    for (int i = 0; i < 40; i++) begin
      pa = int'($urandom_range(0, MASK));
      pb = int'($urandom_range(0, MASK));
      if (i % 8 == 0) pb = 0;
      do_div($sformatf("rnd%0d %0d/%0d", i, pa, pb), pa, pb,
             (i % 5 == 0) ? int'($urandom_range(1, W)) : 0,
             int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
